// File: rtl/keypad_scan_pkg.sv
// keypad_pkg: shared state encoding, matrix geometry and frame helpers for keypad_scan
package keypad_pkg;
    localparam int NUM_COLS = 4;
    localparam int NUM_ROWS = 4;
    localparam int KEY_W    = 4;
    localparam int NUM_KEYS = NUM_COLS * NUM_ROWS;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    // A frame is a single key only when exactly one bit is set
    function automatic logic one_hot(input logic [NUM_KEYS-1:0] f);
        return f != '0 && (f & (f - 1'b1)) == '0;
    endfunction

    // Index of the lowest set bit; only meaningful for one-hot frames
    function automatic logic [KEY_W-1:0] key_idx(input logic [NUM_KEYS-1:0] f);
        logic [KEY_W-1:0] r;
        r = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--)
            if (f[i]) r = KEY_W'(i);
        return r;
    endfunction
endpackage

// File: rtl/keypad_scan_if.sv
// keypad_scan_if: key-matrix pins plus the debounced key report
interface keypad_scan_if import keypad_pkg::*; ();
    logic [NUM_COLS-1:0] o_key_col;
    logic [NUM_ROWS-1:0] i_key_row;
    logic [KEY_W-1:0]    o_key_code;
    logic                o_key_valid;
    logic                o_key_held;

    modport master (output o_key_col, o_key_code, o_key_valid, o_key_held, input i_key_row);
    modport slave  (input o_key_col, o_key_code, o_key_valid, o_key_held, output i_key_row);
endinterface

// File: rtl/keypad_scan_tick.sv
// scan_tick: single-cycle enable every DIV clocks, used to step the column scan
module scan_tick #(
    parameter int DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    output logic tick_o
);
    logic [31:0] cnt_q, cnt_d;

    assign tick_o = cnt_q == 32'(DIV - 1);
    assign cnt_d  = tick_o ? '0 : cnt_q + 32'd1;

    // free-running divider, wraps at DIV-1
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix scanner with frame-level debounce and single-key press reporting
module keypad_scan import keypad_pkg::*; #(
    parameter int SCAN_DIV = 50000,
    parameter int DEB_CNT  = 20
) (
    input  logic          clk,
    input  logic          rst,
    keypad_scan_if.master kp
);
    logic                tick, frame_end, single, match, deb_done;
    logic [NUM_ROWS-1:0] sync1_q, sync2_q, row_act;
    logic [1:0]          col_q;
    logic [NUM_KEYS-1:0] snap_q, frame;
    logic [KEY_W-1:0]    k, cand_q, cand_d, code_q, code_d;
    logic [7:0]          dcnt_q, dcnt_d, dcnt_inc;
    logic                valid_q, valid_d, held_q, held_d;
    state_t              state_q, state_d;

    scan_tick #(.DIV(SCAN_DIV)) u_tick (.clk(clk), .rst(rst), .tick_o(tick));

    // The last column's rows join the snapshot directly so the FSM sees the whole frame on its final tick
    assign row_act   = ~sync2_q;
    assign frame_end = tick && col_q == 2'd3;
    assign frame     = {row_act, snap_q[11:0]};
    assign single    = one_hot(frame);
    assign k         = key_idx(frame);
    assign match     = single && k == cand_q;
    assign dcnt_inc  = dcnt_q + 8'd1;
    assign deb_done  = dcnt_inc == 8'(DEB_CNT);

    assign kp.o_key_col   = ~(4'b0001 << col_q);
    assign kp.o_key_code  = code_q;
    assign kp.o_key_valid = valid_q;
    assign kp.o_key_held  = held_q;

    // row synchronizer, column stepping and per-column row snapshot
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            sync1_q <= '1;
            sync2_q <= '1;
            col_q   <= '0;
            snap_q  <= '0;
        end else begin
            sync1_q <= kp.i_key_row;
            sync2_q <= sync1_q;
            if (tick) begin
                snap_q[{col_q, 2'b00} +: NUM_ROWS] <= row_act;
                col_q <= col_q + 2'd1;
            end
        end

    // debounce state register
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= IDLE;
            cand_q  <= '0;
            dcnt_q  <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            dcnt_q  <= dcnt_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            held_q  <= held_d;
        end

    // per-frame press/release debounce; multi-key frames behave like no key
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        dcnt_d  = dcnt_q;
        code_d  = code_q;
        valid_d = 1'b0;
        held_d  = held_q;
        if (frame_end)
            case (state_q)
                IDLE:
                    if (single) begin
                        cand_d  = k;
                        dcnt_d  = 8'd1;
                        state_d = DEBOUNCE;
                        if (DEB_CNT == 1) begin
                            state_d = PRESSED;
                            dcnt_d  = '0;
                            code_d  = k;
                            valid_d = 1'b1;
                            held_d  = 1'b1;
                        end
                    end
                DEBOUNCE:
                    if (match) begin
                        dcnt_d = dcnt_inc;
                        if (deb_done) begin
                            state_d = PRESSED;
                            dcnt_d  = '0;
                            code_d  = cand_q;
                            valid_d = 1'b1;
                            held_d  = 1'b1;
                        end
                    end else begin
                        state_d = IDLE;
                        dcnt_d  = '0;
                    end
                PRESSED:
                    if (!match) begin
                        state_d = RELEASE;
                        dcnt_d  = 8'd1;
                        if (DEB_CNT == 1) begin
                            state_d = IDLE;
                            dcnt_d  = '0;
                            held_d  = 1'b0;
                        end
                    end
                RELEASE:
                    if (match) begin
                        state_d = PRESSED;
                        dcnt_d  = '0;
                    end else begin
                        dcnt_d = dcnt_inc;
                        if (deb_done) begin
                            state_d = IDLE;
                            dcnt_d  = '0;
                            held_d  = 1'b0;
                        end
                    end
            endcase
    end
endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: directed and random key-matrix frames checked against a frame-level press model
module tb_keypad_scan;
    localparam int DIV = 8;
    localparam int DEB = 3;
    localparam int FRAME = 4 * DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] keys = '0;
    int          total = 0, bad = 0, n = 0;

    bit          m_held;
    int          m_run, m_rel;
    logic [3:0]  m_cand, m_code;
    bit          ev;

    keypad_scan_if kif ();

    keypad_scan #(.SCAN_DIV(DIV), .DEB_CNT(DEB)) dut (.clk(clk), .rst(rst), .kp(kif));

    always #5 clk = ~clk;

    // physical matrix: a pressed key shorts its row to its column while that column is driven low
    always_comb begin
        kif.i_key_row = 4'hF;
        for (int c = 0; c < 4; c++)
            if (!kif.o_key_col[c])
                for (int r = 0; r < 4; r++)
                    if (keys[c * 4 + r]) kif.i_key_row[r] = 1'b0;
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at t=%0t: got %0h, expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_held = 0;
        m_run  = 0;
        m_rel  = 0;
        m_cand = '0;
        m_code = '0;
        ev     = 0;
    endtask

    // one whole frame: a lone key counts toward a press, anything else breaks the streak
    task automatic model_frame(input logic [15:0] m);
        bit         one;
        logic [3:0] key;
        one = $countones(m) == 1;
        key = '0;
        for (int i = 0; i < 16; i++) if (m[i]) key = 4'(i);
        ev = 0;
        if (!m_held) begin
            if (one && m_run > 0 && key == m_cand) m_run++;
            else if (one && m_run == 0) begin
                m_cand = key;
                m_run  = 1;
            end else m_run = 0;
            if (m_run == DEB) begin
                m_held = 1;
                m_code = m_cand;
                ev     = 1;
                m_run  = 0;
            end
        end else if (one && key == m_cand) m_rel = 0;
        else begin
            m_rel++;
            if (m_rel == DEB) begin
                m_held = 0;
                m_rel  = 0;
            end
        end
    endtask

    task automatic run_frame(input logic [15:0] m);
        logic [3:0] ec;
        keys = m;
        for (int i = 0; i < FRAME; i++) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n % FRAME == 0) model_frame(keys);
            else ev = 0;
            ec = ~(4'b0001 << ((n / DIV) % 4));
            chk("col", 16'(kif.o_key_col), 16'(ec));
            chk("valid", 16'(kif.o_key_valid), 16'(ev));
            chk("held", 16'(kif.o_key_held), 16'(m_held));
            chk("code", 16'(kif.o_key_code), 16'(m_code));
        end
    endtask

    task automatic run_n(input logic [15:0] m, input int cnt);
        repeat (cnt) run_frame(m);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_col", 16'(kif.o_key_col), 16'hE);
        chk("rst_valid", 16'(kif.o_key_valid), 16'h0);
        chk("rst_held", 16'(kif.o_key_held), 16'h0);
        chk("rst_code", 16'(kif.o_key_code), 16'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n = 0;
    endtask

    initial begin
        logic [15:0] one, m;
        logic [3:0]  fav;
        int          sel;
        one = 16'd1;
        fav = 4'd9;
        @(negedge clk);
        do_reset();
        run_n(16'h0000, 4);
        run_n(one << 9, 5);
        run_n(16'h0000, 4);
        run_n(one << 9, 2);
        run_n(16'h0000, 1);
        run_n(one << 9, 3);
        run_n(16'h0000, 4);
        run_n((one << 9) | (one << 4), 10);
        run_n(one << 9, 4);
        run_n(16'h0000, 1);
        run_n(one << 9, 2);
        run_n(16'h0000, 3);
        run_n(one << 9, 4);
        run_n(one << 3, 5);
        run_n(16'h0000, 4);
        run_n(one << 9, 2);
        do_reset();
        run_n(one << 9, 4);
        run_n(16'h0000, 4);
        for (int i = 0; i < 120; i++) begin
            sel = $urandom_range(0, 9);
            if ($urandom_range(0, 7) == 0) fav = 4'($urandom_range(0, 15));
            if (sel < 4) m = one << fav;
            else if (sel < 6) m = '0;
            else if (sel < 8) m = one << $urandom_range(0, 15);
            else m = (one << $urandom_range(0, 15)) | (one << $urandom_range(0, 15));
            run_n(m, $urandom_range(1, 5));
            if ($urandom_range(0, 29) == 0) do_reset();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
